pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, giving the number of post-decode stages tracked (entry 0 = EX ... entry NUM_STAGES-1 = WB); legal range 2..8.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, giving the register-address width.
REQ-003 SHALL have parameter REDIRECT_STAGE, default 1, giving the stage that resolves redirects (0 = EX, 1 = MEM); it must be less than NUM_STAGES-1.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock); reset (input, 1, synchronous active-high reset).
REQ-005 SHALL have the decode-stage inputs:
- id_valid_i (input, 1): decode slot holds a real instruction.
- id_rs1_i, id_rs2_i (input, REG_ADDR_W): source registers.
- id_rd_i (input, REG_ADDR_W): destination register.
- id_reg_write_i (input, 1): instruction writes rd.
- id_mem_read_i (input, 1): instruction is a load.
REQ-006 SHALL have redirect_i (input, 1): taken branch or jump resolved in stage REDIRECT_STAGE this cycle.
REQ-007 SHALL have fwd_a_o, fwd_b_o (output, FWD_W = $clog2(NUM_STAGES)): registered forwarding selects for the instruction in EX; 0 = register file, k = result of stage k (1 = EX/MEM, 2 = MEM/WB ...).
REQ-008 SHALL have the pipeline-control outputs:
- stall_o (output, 1): hold PC and IF/ID.
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o (output, 1): squash the named pipe register.
REQ-009 SHALL have stall_cnt_o, flush_cnt_o (output, 32): event counters.

Function
REQ-010 SHALL keep a scoreboard of NUM_STAGES entries {valid, rd, reg_write, mem_read} that shifts by one entry every cycle; the last entry retires.
REQ-011 SHALL load entry 0 with the decode instruction when id_valid_i=1, stall_o=0 and the decode slot is not flushed; otherwise entry 0 SHALL load a bubble (valid=0).
REQ-012 SHALL match a source register only against entries with valid=1, reg_write=1, rd==rs and rd!=0; register 0 never forwards.
REQ-013 SHALL, for each source, choose the youngest (lowest-index) matching entry j with j<NUM_STAGES-1 and register fwd code j+1; a match only in the last entry gives code 0, because the register file writes before it reads in WB.
REQ-014 SHALL assert stall_o combinationally when id_valid_i=1 and entry 0 is a valid load whose rd (nonzero) matches id_rs1_i or id_rs2_i.
REQ-015 SHALL register fwd codes of 0 whenever entry 0 loads a bubble.
REQ-016 SHALL, when redirect_i=1, assert flush_if_id_o and flush_id_ex_o in the same cycle.
REQ-017 SHALL, when redirect_i=1 and REDIRECT_STAGE=1, also assert flush_ex_mem_o and invalidate entry 0 as it shifts to entry 1.
REQ-018 SHALL tie flush_ex_mem_o to 0 when REDIRECT_STAGE=0.
REQ-019 SHALL give redirect priority over stall: when both occur, stall_o=0 and the flush proceeds.
REQ-020 SHALL let the redirecting instruction and all older entries shift unaffected.
REQ-021 SHALL hold a load-use stall for exactly one cycle per hazard; on the next cycle the load sits in entry 1 and forwarding code 2 resolves the hazard.

Reset
REQ-022 SHALL, on reset, clear every scoreboard valid bit, fwd_a_o, fwd_b_o and both counters to 0; stall_o and the flush outputs SHALL read 0 while reset=1.
REQ-023 SHALL let reset asserted mid-stall or mid-flush override both, with no residual stall after reset deasserts.

Configuration
REQ-024 SHALL, with macro PIPE_HAZARD_PERF_EN defined, make stall_cnt_o and flush_cnt_o saturating 32-bit counters incremented once per cycle with stall_o=1 and once per cycle with redirect_i=1, respectively.
REQ-025 SHALL, without PIPE_HAZARD_PERF_EN, keep both counter ports present and drive them constant 0, with no counter flops.

Structure
REQ-026 SHALL place in shared package pipe_hazard_pkg the scoreboard-entry struct typedef and the forwarding-code constants FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2.
REQ-027 SHALL implement the scoreboard shift register as sub-module pipe_scoreboard (parameters NUM_STAGES and REG_ADDR_W; inputs load entry, bubble and invalidate-entry-0; outputs the entry array).

Verification
REQ-028 SHALL cover this scenario: with defaults, "add x5,x1,x2" then "add x6,x5,x3" -> the second instruction's fwd_a_o=1 in EX and stall_o=0.
REQ-029 SHALL cover this scenario: "lw x7,0(x1)" then "add x8,x7,x7" -> stall_o=1 for exactly 1 cycle, then fwd_a_o=fwd_b_o=2 in EX, stall_cnt_o=1 (macro on).
REQ-030 SHALL cover this scenario: "addi x0,x0,5" then "add x9,x0,x0" -> fwd_a_o=fwd_b_o=0.
REQ-031 SHALL cover this scenario: a load-use hazard in ID with redirect_i=1 in the same cycle -> stall_o=0; flush_if_id_o, flush_id_ex_o and flush_ex_mem_o all 1; flush_cnt_o=1.
REQ-032 SHALL cover this scenario: x4 written at distance 1 and at distance 2 by back-to-back producers -> the consumer gets fwd code 1 (youngest wins).
REQ-033 SHALL cover this scenario: reset=1 asserted during a stall cycle -> next cycle stall_o=0, fwd codes 0, counters 0; with the macro undefined the counters always read 0.

Source files
------------

// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: scoreboard entry type, forwarding-select codes and the shared producer-match helper
package pipe_hazard_pkg;

    // Register addresses are zero-extended to this width inside the scoreboard
    localparam int RD_MAX_W = 8;

    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;

    typedef struct packed {
        logic                valid;
        logic [RD_MAX_W-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } sb_entry_t;

    // True when entry e produces register rs; x0 is never produced
    function automatic logic fwd_hit(sb_entry_t e, logic [RD_MAX_W-1:0] rs);
        return e.valid && e.reg_write && e.rd != '0 && e.rd == rs;
    endfunction

    // True when entry e is a load producing register rs
    function automatic logic load_hit(sb_entry_t e, logic [RD_MAX_W-1:0] rs);
        return e.valid && e.mem_read && e.rd != '0 && e.rd == rs;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: shift register of in-flight instructions, entry 0 = EX, last entry = WB
module pipe_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  sb_entry_t                   load_i,
    input  logic                        bubble_i,
    input  logic                        inval0_i,
    output sb_entry_t [NUM_STAGES-1:0]  entries_o
);

    localparam logic [RD_MAX_W-1:0] RD_MASK = RD_MAX_W'((1 << REG_ADDR_W) - 1);

    sb_entry_t [NUM_STAGES-1:0] sb_d, sb_q;

    // Shift by one: decode instruction (or bubble) enters, a squashed EX entry loses its valid bit
    always_comb begin
        sb_d          = {sb_q[NUM_STAGES-2:0], load_i};
        sb_d[0].valid = load_i.valid & ~bubble_i;
        sb_d[0].rd    = load_i.rd & RD_MASK;
        sb_d[1].valid = sb_q[0].valid & ~inval0_i;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (reset) sb_q <= '0;
        else       sb_q <= sb_d;
    end

    assign entries_o = sb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding selects, load-use stall and redirect flushes; PIPE_HAZARD_PERF_EN adds event counters
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int REG_ADDR_W     = 5,
    parameter int REDIRECT_STAGE = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid_i,
    input  logic [REG_ADDR_W-1:0]         id_rs1_i,
    input  logic [REG_ADDR_W-1:0]         id_rs2_i,
    input  logic [REG_ADDR_W-1:0]         id_rd_i,
    input  logic                          id_reg_write_i,
    input  logic                          id_mem_read_i,
    input  logic                          redirect_i,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_a_o,
    output logic [$clog2(NUM_STAGES)-1:0] fwd_b_o,
    output logic                          stall_o,
    output logic                          flush_if_id_o,
    output logic                          flush_id_ex_o,
    output logic                          flush_ex_mem_o,
    output logic [31:0]                   stall_cnt_o,
    output logic [31:0]                   flush_cnt_o
);

    localparam int FWD_W = $clog2(NUM_STAGES);

    sb_entry_t [NUM_STAGES-1:0] sb;
    sb_entry_t                  id_entry;
    logic [RD_MAX_W-1:0]        rs1, rs2;
    logic                       load_use, bubble, inval0;
    logic [FWD_W-1:0]           fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;

    assign rs1      = RD_MAX_W'(id_rs1_i);
    assign rs2      = RD_MAX_W'(id_rs2_i);
    assign id_entry = '{valid: id_valid_i, rd: RD_MAX_W'(id_rd_i),
                        reg_write: id_reg_write_i, mem_read: id_mem_read_i};

    // A load still in EX cannot forward to the instruction entering EX next cycle
    assign load_use       = load_hit(sb[0], rs1) || load_hit(sb[0], rs2);
    assign stall_o        = ~reset & id_valid_i & load_use & ~redirect_i;
    assign flush_if_id_o  = ~reset & redirect_i;
    assign flush_id_ex_o  = ~reset & redirect_i;
    assign flush_ex_mem_o = (REDIRECT_STAGE == 1) && !reset && redirect_i;
    assign bubble         = ~id_valid_i | stall_o | redirect_i;
    assign inval0         = (REDIRECT_STAGE == 1) && redirect_i;

    pipe_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .load_i    (id_entry),
        .bubble_i  (bubble),
        .inval0_i  (inval0),
        .entries_o (sb)
    );

    // Youngest producer wins: scan oldest to youngest so later hits overwrite; the retiring entry reads the RF
    always_comb begin
        fwd_a_d = FWD_W'(FWD_RF);
        fwd_b_d = FWD_W'(FWD_RF);
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (fwd_hit(sb[j], rs1)) fwd_a_d = (j == NUM_STAGES - 1) ? FWD_W'(FWD_RF) : FWD_W'(FWD_EXMEM + j);
            if (fwd_hit(sb[j], rs2)) fwd_b_d = (j == NUM_STAGES - 1) ? FWD_W'(FWD_RF) : FWD_W'(FWD_EXMEM + j);
        end
        if (bubble) begin
            fwd_a_d = FWD_W'(FWD_RF);
            fwd_b_d = FWD_W'(FWD_RF);
        end
    end

    // Forwarding selects travel with the instruction into EX
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall and redirect event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redirect_i && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed hazard scenarios with hand-computed forwarding, stall and flush values
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid, id_reg_write, id_mem_read, redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush_if_id, flush_id_ex, flush_ex_mem;
    logic [31:0] stall_cnt, flush_cnt;
    int          total = 0;
    int          bad = 0;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .redirect_i     (redirect),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .stall_o        (stall),
        .flush_if_id_o  (flush_if_id),
        .flush_id_ex_o  (flush_id_ex),
        .flush_ex_mem_o (flush_ex_mem),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic we, input logic ld, input logic rdr);
        id_valid     = v;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_reg_write = we;
        id_mem_read  = ld;
        redirect     = rdr;
        #1;
    endtask

    task automatic drain;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("rst_stall", stall, 0);
        check("rst_flush", flush_if_id, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_fwd_b", fwd_b, 0);
        check("rst_scnt", stall_cnt, 0);
        check("rst_fcnt", flush_cnt, 0);
        reset = 1'b0;

        // add x5,x1,x2 ; add x6,x5,x3
        drive(1, 5, 1, 2, 1, 0, 0);
        check("alu_nostall0", stall, 0);
        tick;
        check("alu_first_fwd", fwd_a, 0);
        drive(1, 6, 5, 3, 1, 0, 0);
        check("alu_nostall1", stall, 0);
        tick;
        check("alu_fwd_a", fwd_a, 1);
        check("alu_fwd_b", fwd_b, 0);
        drain;

        // lw x7,0(x1) ; add x8,x7,x7
        drive(1, 7, 1, 0, 1, 1, 0);
        check("lu_lw_nostall", stall, 0);
        tick;
        drive(1, 8, 7, 7, 1, 0, 0);
        check("lu_stall", stall, 1);
        tick;
        check("lu_stall_once", stall, 0);
        check("lu_bubble_fwd", fwd_a, 0);
        tick;
        check("lu_fwd_a", fwd_a, 2);
        check("lu_fwd_b", fwd_b, 2);
        check("lu_scnt", stall_cnt, PERF);
        drain;

        // addi x0,x0,5 ; add x9,x0,x0
        drive(1, 0, 0, 0, 1, 0, 0);
        tick;
        drive(1, 9, 0, 0, 1, 0, 0);
        check("x0_nostall", stall, 0);
        tick;
        check("x0_fwd_a", fwd_a, 0);
        check("x0_fwd_b", fwd_b, 0);
        drain;

        // load-use hazard coinciding with a redirect
        drive(1, 7, 1, 0, 1, 1, 0);
        tick;
        drive(1, 8, 7, 7, 1, 0, 1);
        check("rd_nostall", stall, 0);
        check("rd_fl_ifid", flush_if_id, 1);
        check("rd_fl_idex", flush_id_ex, 1);
        check("rd_fl_exmem", flush_ex_mem, 1);
        tick;
        check("rd_bubble_fwd", fwd_a, 0);
        check("rd_fcnt", flush_cnt, PERF);
        drive(1, 10, 7, 0, 1, 0, 0);
        check("rd_after_stall", stall, 0);
        check("rd_after_flush", flush_if_id, 0);
        tick;
        check("rd_inval_fwd", fwd_a, 0);
        check("rd_scnt", stall_cnt, PERF);
        drain;

        // x4 at distance 1 and 2: youngest wins
        drive(1, 4, 1, 2, 1, 0, 0);
        tick;
        drive(1, 4, 3, 3, 1, 0, 0);
        tick;
        drive(1, 11, 4, 4, 1, 0, 0);
        tick;
        check("yw_fwd_a", fwd_a, 1);
        check("yw_fwd_b", fwd_b, 1);
        drain;

        // x4 at distance 2 only
        drive(1, 4, 1, 2, 1, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        drive(1, 12, 0, 4, 1, 0, 0);
        tick;
        check("d2_fwd_a", fwd_a, 0);
        check("d2_fwd_b", fwd_b, 2);
        drain;

        // x4 in WB when the consumer enters EX: register file supplies it
        drive(1, 4, 1, 2, 1, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        drive(1, 13, 4, 0, 1, 0, 0);
        tick;
        check("wb_fwd_a", fwd_a, 0);
        drain;

        // reset during a stall cycle
        drive(1, 7, 1, 0, 1, 1, 0);
        tick;
        drive(1, 8, 7, 7, 1, 0, 0);
        check("rs_stall", stall, 1);
        reset = 1'b1;
        #1;
        check("rs_stall_in_rst", stall, 0);
        redirect = 1'b1;
        #1;
        check("rs_flush_in_rst", flush_if_id, 0);
        check("rs_flush_exmem_in_rst", flush_ex_mem, 0);
        tick;
        reset = 1'b0;
        redirect = 1'b0;
        #1;
        check("rs_post_stall", stall, 0);
        check("rs_post_fwd_a", fwd_a, 0);
        check("rs_post_fwd_b", fwd_b, 0);
        check("rs_post_scnt", stall_cnt, 0);
        check("rs_post_fcnt", flush_cnt, 0);
        drain;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
